// File: rtl/divisor_seq.sv
// rtl/divisor_seq.sv - restoring divider with quotient/remainder LED display sequencer
// One quotient bit per clock; result shown on LEDs, divide-by-zero shown as a blink.
module divisor_seq #(
  parameter int W          = 4,
  parameter int BLINK_BITS = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         show_tick,
  input  logic [W-1:0] num,
  input  logic [W-1:0] den,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [W-1:0] leds
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CALC   = 3'd1,
    SHOW_Q = 3'd2,
    SHOW_R = 3'd3,
    ERR    = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [W-1:0]          d_q, d_d;
  logic [W-1:0]          r_q, r_d;
  logic [W-1:0]          q_q, q_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [W-1:0]          quotient_q, quotient_d;
  logic [W-1:0]          remainder_q, remainder_d;
  logic                  done_q, done_d;
  logic [BLINK_BITS-1:0] blink_q, blink_d;

  logic                  accept;
  logic                  den_zero;
  logic                  last_step;
  logic [W:0]            r_sh;
  logic [W:0]            diff;
  logic                  ge;
  logic [W-1:0]          r_step;
  logic [W-1:0]          q_step;

  assign accept    = start && (state_q != CALC);
  assign den_zero  = (den == '0);
  assign last_step = (state_q == CALC) && (cnt_q == CW'(1));

  // The held remainder is always < D, so it fits W bits; the shifted value
  // needs W+1 and the borrow out of the W+1-bit subtract is the compare result.
  always_comb begin
    r_sh   = {r_q, q_q[W-1]};
    diff   = r_sh - {1'b0, d_q};
    ge     = ~diff[W];
    r_step = ge ? diff[W-1:0] : r_sh[W-1:0];
    q_step = {q_q[W-2:0], ge};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = den_zero ? ERR : CALC;
    end else begin
      case (state_q)
        CALC:    if (last_step) state_d = SHOW_Q;
        SHOW_Q:  if (show_tick) state_d = SHOW_R;
        SHOW_R:  if (show_tick) state_d = SHOW_Q;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    busy        = (state_q == CALC);
    div_by_zero = (state_q == ERR);
    case (state_q)
      SHOW_Q:  leds = quotient_q;
      SHOW_R:  leds = remainder_q;
      ERR:     leds = {W{blink_q[BLINK_BITS-1]}};
      default: leds = '0;
    endcase
  end

  always_comb begin
    d_d         = d_q;
    r_d         = r_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    done_d      = 1'b0;
    blink_d     = blink_q;
    if (accept) begin
      if (den_zero) begin
        blink_d = '0;
      end else begin
        d_d   = den;
        r_d   = '0;
        q_d   = num;
        cnt_d = CW'(W);
      end
    end else if (state_q == CALC) begin
      r_d   = r_step;
      q_d   = q_step;
      cnt_d = cnt_q - CW'(1);
      if (last_step) begin
        quotient_d  = q_step;
        remainder_d = r_step;
        done_d      = 1'b1;
      end
    end else if (state_q == ERR) begin
      blink_d = blink_q + BLINK_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_q         <= '0;
      r_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      blink_q     <= '0;
    end else begin
      d_q         <= d_d;
      r_q         <= r_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
      blink_q     <= blink_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign done      = done_q;

endmodule
